// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and a debug/loader port; single-cycle access, loads return 1 cycle later.
// The loser sees no ack (CPU via cpu_stall); debug is forced through after STARVE_MAX losses and may hold bursts of BURST_MAX beats.
module dmem_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int BURST_MAX  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [2:0]  cpu_sel,
   input  logic [10:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ack,
   output logic        cpu_stall,
   output logic        cpu_misalign,
   output logic [31:0] cpu_rdata,
   output logic        cpu_rvalid,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic        dbg_burst,
   input  logic [10:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_ack,
   output logic [31:0] dbg_rdata,
   output logic        dbg_rvalid,
   output logic        write_enable_dmem,
   output logic [2:0]  store_sel_M,
   output logic [10:0] mem_WA,
   output logic [31:0] mem_WD,
   input  logic [31:0] mem_RD
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam int BW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
   localparam logic [2:0] SEL_WORD = 3'b010;

   typedef enum logic [1:0] {IDLE, CPU_OWN, DBG_BURST} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [BW-1:0] burst_q, burst_d;
   logic [31:0]   cpu_rdata_q, dbg_rdata_q;
   logic          cpu_rvalid_q, dbg_rvalid_q;

   logic cpu_gnt, dbg_gnt, sel_bad, last_beat;

   always_comb begin
      case (cpu_sel)
         3'b000:  sel_bad = 1'b0;
         3'b001:  sel_bad = cpu_addr[0];
         3'b010:  sel_bad = |cpu_addr[1:0];
         default: sel_bad = 1'b1;
      endcase
   end

   // Grants are forced low while reset is held so no stray strobe reaches memory.
   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (rst_n) begin
         if (state_q == DBG_BURST) begin
            dbg_gnt = dbg_req;
         end else if (cpu_req && dbg_req) begin
            if (starve_q == SMAX) dbg_gnt = 1'b1;
            else                  cpu_gnt = 1'b1;
         end else begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req;
         end
      end
   end

   always_comb begin
      write_enable_dmem = 1'b0;
      store_sel_M       = SEL_WORD;
      mem_WA            = '0;
      mem_WD            = '0;
      if (cpu_gnt) begin
         write_enable_dmem = cpu_we & ~sel_bad;
         store_sel_M       = cpu_sel;
         mem_WA            = cpu_addr;
         mem_WD            = cpu_wdata;
      end else if (dbg_gnt) begin
         write_enable_dmem = dbg_we;
         mem_WA            = dbg_addr;
         mem_WD            = dbg_wdata;
      end
   end

   assign last_beat = (int'(burst_q) + 1) >= BURST_MAX;

   always_comb begin
      state_d  = state_q;
      burst_d  = burst_q;
      starve_d = starve_q;
      if (dbg_gnt)
         starve_d = '0;
      else if (cpu_gnt && dbg_req && starve_q != SMAX)
         starve_d = starve_q + 1'b1;

      case (state_q)
         DBG_BURST: begin
            if (!dbg_req || !dbg_burst || last_beat) begin
               state_d = IDLE;
               burst_d = '0;
            end else begin
               burst_d = burst_q + 1'b1;
            end
         end
         default: begin
            burst_d = '0;
            if (cpu_gnt) begin
               state_d = CPU_OWN;
            end else if (dbg_gnt && dbg_burst && BURST_MAX > 1) begin
               state_d = DBG_BURST;
               burst_d = BW'(1);
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         starve_q     <= '0;
         burst_q      <= '0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         burst_q      <= burst_d;
         cpu_rvalid_q <= cpu_gnt & ~cpu_we & ~sel_bad;
         dbg_rvalid_q <= dbg_gnt & ~dbg_we;
         if (cpu_gnt && !cpu_we && !sel_bad) cpu_rdata_q <= mem_RD;
         if (dbg_gnt && !dbg_we)             dbg_rdata_q <= mem_RD;
      end
   end

   assign cpu_ack      = cpu_gnt;
   assign dbg_ack      = dbg_gnt;
   assign cpu_stall    = cpu_req & ~cpu_gnt;
   assign cpu_misalign = cpu_gnt & sel_bad;
   assign cpu_rdata    = cpu_rdata_q;
   assign cpu_rvalid   = cpu_rvalid_q;
   assign dbg_rdata    = dbg_rdata_q;
   assign dbg_rvalid   = dbg_rvalid_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: the maximum number of consecutive cycles the debug port loses arbitration before it is forced to win.
REQ-002 SHALL have parameter BURST_MAX, default 8: the maximum number of cycles in one debug burst.
REQ-003 SHALL have the port list below, one clock, asynchronous active-low reset.
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- cpu_req  in  1  MEM-stage access request, held until cpu_ack
- cpu_we  in  1  1=store, 0=load
- cpu_sel  in  3  000 byte, 001 half, 010 word
- cpu_addr  in  11  byte address
- cpu_wdata  in  32  store data, LSB-aligned
- cpu_ack  out  1  access completed this cycle
- cpu_stall  out  1  cpu_req & ~cpu_ack
- cpu_misalign  out  1  one-cycle error pulse
- cpu_rdata  out  32  registered load word
- cpu_rvalid  out  1  cpu_rdata valid
- dbg_req  in  1  debug/loader request, held until dbg_ack
- dbg_we  in  1  1=store word, 0=load word
- dbg_burst  in  1  keep ownership after this beat
- dbg_addr  in  11  byte address, word aligned
- dbg_wdata  in  32  store data
- dbg_ack  out  1  beat completed this cycle
- dbg_rdata  out  32  registered load word
- dbg_rvalid  out  1  dbg_rdata valid
- write_enable_dmem  out  1  memory write strobe
- store_sel_M  out  3  memory store width
- mem_WA  out  11  memory byte address
- mem_WD  out  32  memory write data
- mem_RD  in  32  combinational memory read word at mem_WA[10:2]

Function
REQ-004 SHALL implement FSM states IDLE, CPU_OWN, DBG_BURST; the state register is updated on the clk rising edge.
REQ-005 In IDLE/CPU_OWN SHALL grant per cycle: CPU only -> CPU; debug only -> debug; both -> CPU unless starve_cnt==STARVE_MAX, then debug.
REQ-006 starve_cnt SHALL increment (saturating at STARVE_MAX) each cycle dbg_req is pending and CPU wins, and SHALL clear on any dbg_ack.
REQ-007 The granted requester SHALL drive mem_WA/mem_WD/store_sel_M in the same cycle; its ack SHALL be asserted combinationally in that cycle; the access is single-cycle.
REQ-008 write_enable_dmem SHALL equal the granted requester's we, gated to 0 for a misaligned CPU access and for no grant.
REQ-009 Debug accesses SHALL always use store_sel_M=010; when nothing is granted, store_sel_M=010 and mem_WA=0, mem_WD=0.
REQ-010 A CPU access with cpu_sel=001 and addr[0]=1, cpu_sel=010 and addr[1:0]!=0, or cpu_sel in {011..111} SHALL be misaligned: it is acked with cpu_misalign=1, no write, and cpu_rvalid=0 next cycle.
REQ-011 On a granted load, mem_RD SHALL be registered into cpu_rdata/dbg_rdata with the matching rvalid=1 on the following cycle only (1-cycle load latency); rdata holds its value otherwise.
REQ-012 A CPU-granted cycle SHALL move the state to CPU_OWN; a cycle with no grant SHALL move it to IDLE (CPU_OWN is informational, with the same arbitration as IDLE).
REQ-013 A debug grant with dbg_burst=1 SHALL enter DBG_BURST with burst_cnt=1; in DBG_BURST debug wins unconditionally, and cpu_req stalls.
REQ-014 DBG_BURST SHALL exit to IDLE after a beat with dbg_burst=0, after the BURST_MAX-th beat, or when dbg_req=0; the exit cycle still grants debug if dbg_req=1.
REQ-015 In DBG_BURST, a cycle with dbg_req=0 SHALL issue no memory access.
REQ-016 A request deasserted before its ack SHALL be dropped with no memory effect.

Reset
REQ-017 With rst_n low, the block SHALL be in state IDLE with starve_cnt=0, burst_cnt=0, cpu_rdata=0, dbg_rdata=0, both rvalid=0 and cpu_misalign=0; write_enable_dmem, cpu_ack and dbg_ack SHALL be 0.
REQ-018 Reset assertion mid-burst SHALL abort the burst immediately; the first cycle after release SHALL arbitrate from IDLE.

Verification
REQ-019 CPU store byte: cpu_sel=000, addr=0x005, wdata=0xAB -> same cycle write_enable_dmem=1, mem_WA=0x005, store_sel_M=000, cpu_ack=1.
REQ-020 Contention: both ports request continuously, STARVE_MAX=4 -> CPU acked 4 cycles, debug acked on cycle 5, starve_cnt=0 afterwards.
REQ-021 Misaligned: cpu_sel=010, addr=0x006, cpu_we=1 -> cpu_ack=1, cpu_misalign=1, write_enable_dmem=0.
REQ-022 Load: memory word at 0x010 preloaded with 0x12345678, CPU load -> cpu_rvalid=1 with cpu_rdata=0x12345678 on the next cycle.
REQ-023 Burst: dbg_burst held 1 for 10 beats with cpu_req=1 -> 8 debug acks (BURST_MAX) with cpu_stall=1, then CPU acked on the next contention cycle.
REQ-024 rst_n pulsed low at burst beat 3 -> outputs zeroed; after release, CPU wins the first contention.
